// File: rtl/ibex_zkn_aes32_ctrl_pkg.sv
// rtl/ibex_zkn_aes32_ctrl_pkg.sv - shared types and GF(2^8) helpers for the AES32 sequencer
package ibex_zkn_aes32_ctrl_pkg;

  typedef enum logic [1:0] {
    ZKN_AES32ESI  = 2'd0,
    ZKN_AES32ESMI = 2'd1,
    ZKN_AES32DSI  = 2'd2,
    ZKN_AES32DSMI = 2'd3
  } zkn_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } zkn_state_e;

  function automatic logic [7:0] aes_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Multiply by a small constant (2/3/9/b/d/e) as a sum of xtime powers.
  function automatic logic [7:0] aes_gfmul4(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = x;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) acc = acc ^ p;
      p = aes_xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] aes_gfmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = aes_xtime(p);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse and conveniently maps 0 to 0.
  function automatic logic [7:0] aes_gfinv(input logic [7:0] x);
    logic [7:0] t;
    t = aes_gfmul(aes_gfmul(x, x), x);   // x^3
    t = aes_gfmul(aes_gfmul(t, t), x);   // x^7
    t = aes_gfmul(aes_gfmul(t, t), x);   // x^15
    t = aes_gfmul(aes_gfmul(t, t), x);   // x^31
    t = aes_gfmul(aes_gfmul(t, t), x);   // x^63
    t = aes_gfmul(aes_gfmul(t, t), x);   // x^127
    return aes_gfmul(t, t);              // x^254
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [31:0] rol32_bytes(input logic [31:0] x, input logic [1:0] nb);
    logic [63:0] d;
    d = {x, x} << {nb, 3'b000};
    return d[63:32];
  endfunction

endpackage

// File: rtl/ibex_aes_sbox.sv
// rtl/ibex_aes_sbox.sv - combinational AES forward/inverse S-box
module ibex_aes_sbox
  import ibex_zkn_aes32_ctrl_pkg::*;
#(
  parameter bit EnInv = 1'b1
) (
  input  logic       inv_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  logic [7:0] fwd_inv;
  logic [7:0] fwd;
  logic [7:0] inv;

  assign fwd_inv = aes_gfinv(data_i);
  assign fwd     = fwd_inv ^ rol8(fwd_inv, 3'd1) ^ rol8(fwd_inv, 3'd2) ^
                   rol8(fwd_inv, 3'd3) ^ rol8(fwd_inv, 3'd4) ^ 8'h63;

  if (EnInv) begin : g_inv
    assign inv = aes_gfinv(rol8(data_i, 3'd1) ^ rol8(data_i, 3'd3) ^
                           rol8(data_i, 3'd6) ^ 8'h05);
  end else begin : g_no_inv
    assign inv = 8'h00;
  end

  assign data_o = inv_i ? inv : fwd;

endmodule

// File: rtl/ibex_zkn_aes32_ctrl.sv
// rtl/ibex_zkn_aes32_ctrl.sv - multi-cycle sequencer for the AES32 byte-round instructions
module ibex_zkn_aes32_ctrl
  import ibex_zkn_aes32_ctrl_pkg::*;
#(
  parameter bit EnDecrypt = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        kill_i,
  input  logic [1:0]  operator_i,
  input  logic [1:0]  bs_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic        ready_id_i,
  output logic        valid_o,
  output logic        busy_o,
  output logic [31:0] result_o
);

  zkn_state_e state_q, state_d;
  zkn_op_e    op_q;
  logic [1:0]  bs_q;
  logic [31:0] rs1_q;
  logic [7:0]  byte_q;
  logic [7:0]  sbox_q;
  logic [31:0] result_q;
  logic [7:0]  sbox_out;
  logic        is_dec;
  logic        start;
  logic [31:0] w;
  logic [31:0] result_d;

  assign start  = (state_q == IDLE) && en_i && !kill_i;
  assign is_dec = (op_q == ZKN_AES32DSI) || (op_q == ZKN_AES32DSMI);

  ibex_aes_sbox #(
    .EnInv (EnDecrypt)
  ) u_sbox (
    .inv_i  (is_dec),
    .data_i (byte_q),
    .data_o (sbox_out)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // kill_i overrides every other transition, including retirement and start.
  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (en_i) state_d = SUB;
        SUB:     state_d = MIX;
        MIX:     state_d = DONE;
        DONE:    if (ready_id_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    w = 32'h0;
    unique case (op_q)
      ZKN_AES32ESI:  w = {24'h0, sbox_q};
      ZKN_AES32ESMI: w = {aes_gfmul4(sbox_q, 4'h3), sbox_q, sbox_q, aes_gfmul4(sbox_q, 4'h2)};
      ZKN_AES32DSI:  w = {24'h0, sbox_q};
      ZKN_AES32DSMI: w = {aes_gfmul4(sbox_q, 4'hB), aes_gfmul4(sbox_q, 4'hD),
                          aes_gfmul4(sbox_q, 4'h9), aes_gfmul4(sbox_q, 4'hE)};
      default:       w = 32'h0;
    endcase
    // Without the inverse datapath, decrypt ops collapse to a pass-through of rs1.
    if (!EnDecrypt && is_dec) w = 32'h0;
    result_d = rs1_q ^ rol32_bytes(w, bs_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= ZKN_AES32ESI;
      bs_q     <= 2'b00;
      rs1_q    <= 32'h0;
      byte_q   <= 8'h00;
      sbox_q   <= 8'h00;
      result_q <= 32'h0;
    end else begin
      if (start) begin
        op_q   <= zkn_op_e'(operator_i);
        bs_q   <= bs_i;
        rs1_q  <= operand_a_i;
        byte_q <= operand_b_i[{bs_i, 3'b000} +: 8];
      end
      if (state_q == SUB && !kill_i) sbox_q <= sbox_out;
      if (state_q == MIX && !kill_i) result_q <= result_d;
    end
  end

  assign valid_o  = (state_q == DONE);
  assign busy_o   = (state_q != IDLE);
  assign result_o = result_q;

endmodule

// File: tb/tb_ibex_zkn_aes32_ctrl.sv
// tb/tb_ibex_zkn_aes32_ctrl.sv - directed vector bench for the AES32 sequencer
module tb_ibex_zkn_aes32_ctrl;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  bs;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_full;
    logic [31:0] exp_nodec;
  } vec_t;

  localparam int NV = 12;

  logic        clk;
  logic        rst;
  logic        en;
  logic        kill;
  logic [1:0]  op;
  logic [1:0]  bs;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        valid1, busy1, valid0, busy0;
  logic [31:0] res1, res0;

  int n_tests;
  int n_fail;
  vec_t vecs[NV];
  logic [31:0] exp_last;

  ibex_zkn_aes32_ctrl #(.EnDecrypt(1'b1)) dut_full (
    .clk_i(clk), .rst_i(rst), .en_i(en), .kill_i(kill), .operator_i(op), .bs_i(bs),
    .operand_a_i(a), .operand_b_i(b), .ready_id_i(ready),
    .valid_o(valid1), .busy_o(busy1), .result_o(res1)
  );

  ibex_zkn_aes32_ctrl #(.EnDecrypt(1'b0)) dut_nodec (
    .clk_i(clk), .rst_i(rst), .en_i(en), .kill_i(kill), .operator_i(op), .bs_i(bs),
    .operand_a_i(a), .operand_b_i(b), .ready_id_i(ready),
    .valid_o(valid0), .busy_o(busy0), .result_o(res0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Pulse en for one cycle, then scramble the inputs so only the captured copies matter.
  task automatic start_op(input logic [1:0] o, input logic [1:0] s,
                          input logic [31:0] ra, input logic [31:0] rb);
    op = o; bs = s; a = ra; b = rb; en = 1'b1;
    tick();
    en = 1'b0;
    op = 2'($urandom); bs = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; en = 1'b0; kill = 1'b0; ready = 1'b0;
    op = 2'd0; bs = 2'd0; a = 32'h0; b = 32'h0;

    vecs[0]  = '{2'd0, 2'd0, 32'h00000000, 32'h00000000, 32'h00000063, 32'h00000063};
    vecs[1]  = '{2'd0, 2'd2, 32'h00000001, 32'h00530000, 32'h00ED0001, 32'h00ED0001};
    vecs[2]  = '{2'd1, 2'd0, 32'h00000000, 32'h00000001, 32'h847C7CF8, 32'h847C7CF8};
    vecs[3]  = '{2'd1, 2'd1, 32'h00000000, 32'h00000100, 32'h7C7CF884, 32'h7C7CF884};
    vecs[4]  = '{2'd2, 2'd0, 32'h00000000, 32'h00000063, 32'h00000000, 32'h00000000};
    vecs[5]  = '{2'd3, 2'd0, 32'h00000000, 32'h0000007C, 32'h0B0D090E, 32'h00000000};
    vecs[6]  = '{2'd3, 2'd0, 32'hDEADBEEF, 32'h0000007C, 32'hD5A0B7E1, 32'hDEADBEEF};
    vecs[7]  = '{2'd2, 2'd0, 32'hDEADBEEF, 32'h00000063, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[8]  = '{2'd0, 2'd3, 32'h12345678, 32'h01000000, 32'h6E345678, 32'h6E345678};
    vecs[9]  = '{2'd2, 2'd1, 32'h00000000, 32'h0000ED00, 32'h00005300, 32'h00000000};
    vecs[10] = '{2'd1, 2'd2, 32'h00000000, 32'h00530000, 32'hEDC12CED, 32'hEDC12CED};
    vecs[11] = '{2'd0, 2'd1, 32'h00000000, 32'hFFFF00FF, 32'h00006300, 32'h00006300};

    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_busy_valid", {30'h0, busy1, valid1}, 32'h0);
    chk("reset_result", res1, 32'h0);
    chk("reset_nodec_result", res0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i].op, vecs[i].bs, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_sub_bv", i), {30'h0, busy1, valid1}, 32'h2);
      tick();
      chk($sformatf("v%0d_mix_bv", i), {30'h0, busy1, valid1}, 32'h2);
      tick();
      chk($sformatf("v%0d_done_bv", i), {30'h0, busy1, valid1}, 32'h3);
      chk($sformatf("v%0d_result", i), res1, vecs[i].exp_full);
      chk($sformatf("v%0d_nodec_valid", i), {31'h0, valid0}, 32'h1);
      chk($sformatf("v%0d_nodec_result", i), res0, vecs[i].exp_nodec);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk($sformatf("v%0d_idle_bv", i), {30'h0, busy1, valid1}, 32'h0);
      chk($sformatf("v%0d_hold_result", i), res1, vecs[i].exp_full);
    end

    // Stall in DONE, then retire with en held high across the return to IDLE.
    start_op(2'd0, 2'd0, 32'h0, 32'h0);
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_bv", k), {30'h0, busy1, valid1}, 32'h3);
      chk($sformatf("stall%0d_result", k), res1, 32'h00000063);
      tick();
    end
    chk("stall_end_result", res1, 32'h00000063);
    ready = 1'b1; en = 1'b1; op = 2'd1; bs = 2'd0; a = 32'h0; b = 32'h1;
    tick();
    ready = 1'b0;
    chk("retire_idle_bv", {30'h0, busy1, valid1}, 32'h0);
    tick();
    en = 1'b0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    chk("b2b_accept_bv", {30'h0, busy1, valid1}, 32'h2);
    tick(); tick();
    chk("b2b_done_bv", {30'h0, busy1, valid1}, 32'h3);
    chk("b2b_result", res1, 32'h847C7CF8);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    exp_last = 32'h847C7CF8;

    // Kill in SUB (1), MIX (2) and DONE (3); in DONE ready is raised too.
    for (int k = 1; k <= 3; k++) begin
      start_op(2'd0, 2'd0, 32'h0, 32'h00000001);
      for (int j = 1; j < k; j++) tick();
      kill = 1'b1;
      ready = (k == 3);
      tick();
      kill = 1'b0; ready = 1'b0;
      if (k == 3) exp_last = 32'h0000007C;
      chk($sformatf("kill%0d_bv", k), {30'h0, busy1, valid1}, 32'h0);
      chk($sformatf("kill%0d_result", k), res1, exp_last);
      tick();
      chk($sformatf("kill%0d_after_bv", k), {30'h0, busy1, valid1}, 32'h0);
    end

    en = 1'b1; kill = 1'b1; op = 2'd0; b = 32'h0;
    tick();
    en = 1'b0; kill = 1'b0;
    chk("kill_vs_en_bv", {30'h0, busy1, valid1}, 32'h0);

    // Reset during MIX clears data registers as well as the FSM.
    start_op(2'd1, 2'd0, 32'h0, 32'h00000001);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mix_bv", {30'h0, busy1, valid1}, 32'h0);
    chk("rst_mix_result", res1, 32'h0);
    tick();
    chk("rst_after_bv", {30'h0, busy1, valid1}, 32'h0);

    start_op(2'd0, 2'd2, 32'h00000001, 32'h00530000);
    tick(); tick();
    chk("recover_bv", {30'h0, busy1, valid1}, 32'h3);
    chk("recover_result", res1, 32'h00ED0001);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
